// File: rtl/prio_arb_4ch.sv
// prio_arb_4ch: four-requester arbiter with a hold limit per owner.
// An owner keeps the grant until it signals done, drops its request, or has
// held for MAX_HOLD cycles. Every release is followed by one idle cycle.
// tout flags a release forced only by the hold limit.
// Optional build macro ARB_RR_EN: round-robin winner selection (a pointer
// register remembers the last owner). Without it, the highest requesting
// index wins.
module prio_arb_4ch #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_v,
  output logic       tout
);

  localparam int CNT_W = $clog2(MAX_HOLD);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
  logic [3:0]       gnt_n;
  logic [1:0]       gnt_id_n;
  logic             gnt_v_n;
  logic             tout_n;
  logic [1:0]       win;
  logic             rel_norm;
  logic             rel_lim;

`ifdef ARB_RR_EN
  logic [1:0] last, last_n;

  // Search last-1, last-2, last-3, last (mod 4); first requesting index wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] w;
    logic [1:0] idx;
    logic       found;
    w     = p;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = p - 2'(k);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction
`else
  // Highest set index wins (3 > 2 > 1 > 0).
  function automatic logic [1:0] fixed_pick(input logic [3:0] r);
    logic [1:0] w;
    w = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) w = 2'(i);
    end
    return w;
  endfunction
`endif

  // State and registered outputs; reset drops the grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      gnt_id   <= 2'd0;
      gnt_v    <= 1'b0;
      tout     <= 1'b0;
      hold_cnt <= '0;
`ifdef ARB_RR_EN
      last     <= 2'd0;
`endif
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_id   <= gnt_id_n;
      gnt_v    <= gnt_v_n;
      tout     <= tout_n;
      hold_cnt <= hold_cnt_n;
`ifdef ARB_RR_EN
      last     <= last_n;
`endif
    end
  end

  // Next-state, winner selection and next values of the output registers.
  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    gnt_id_n   = gnt_id;
    gnt_v_n    = gnt_v;
    tout_n     = 1'b0;
    hold_cnt_n = hold_cnt;
`ifdef ARB_RR_EN
    last_n     = last;
    win        = rr_pick(req, last);
`else
    win        = fixed_pick(req);
`endif
    rel_norm   = done || !req[gnt_id];
    rel_lim    = (hold_cnt == CNT_W'(MAX_HOLD - 1));

    case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          state_n    = BUSY;
          gnt_n      = 4'b0001 << win;
          gnt_id_n   = win;
          gnt_v_n    = 1'b1;
          hold_cnt_n = '0;
`ifdef ARB_RR_EN
          last_n     = win;
`endif
        end else begin
          gnt_n    = 4'b0000;
          gnt_id_n = 2'd0;
          gnt_v_n  = 1'b0;
        end
      end
      BUSY: begin
        if (rel_norm || rel_lim) begin
          // A normal release takes precedence, so tout marks only pure timeouts.
          state_n    = IDLE;
          gnt_n      = 4'b0000;
          gnt_id_n   = 2'd0;
          gnt_v_n    = 1'b0;
          hold_cnt_n = '0;
          tout_n     = rel_lim && !rel_norm;
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n    = IDLE;
        gnt_n      = 4'b0000;
        gnt_id_n   = 2'd0;
        gnt_v_n    = 1'b0;
        hold_cnt_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_prio_arb_4ch.sv
// tb_prio_arb_4ch: directed bench for prio_arb_4ch with MAX_HOLD = 16.
module tb_prio_arb_4ch;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_v;
  logic       tout;

  int vectors;
  int miscompares;

  prio_arb_4ch #(.MAX_HOLD(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .done   (done),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .gnt_v  (gnt_v),
    .tout   (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    #2;
    vectors++;
    if (gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    vectors++;
    if (gnt_id !== 2'd0) begin miscompares++; $display("FAIL reset_id got %0d want 0", gnt_id); end
    vectors++;
    if (gnt_v !== 1'b0) begin miscompares++; $display("FAIL reset_v got %b want 0", gnt_v); end
    vectors++;
    if (tout !== 1'b0) begin miscompares++; $display("FAIL reset_tout got %b want 0", tout); end
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_idle();
    req  = 4'b0000;
    done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (gnt_v !== 1'b0 || gnt !== 4'b0000) begin
        miscompares++;
        $display("FAIL idle_hold cyc %0d got v=%b gnt=%b want v=0 gnt=0000", i, gnt_v, gnt);
      end
    end
    done = 1'b0;
  endtask

  task automatic test_basic();
    req = 4'b0101;
    step();
    vectors++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2 || gnt_v !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_grant got gnt=%b id=%0d v=%b want 0100/2/1", gnt, gnt_id, gnt_v);
    end
    done = 1'b1;
    req  = 4'b0000;
    step();
    done = 1'b0;
    vectors++;
    if (gnt_v !== 1'b0 || tout !== 1'b0 || gnt !== 4'b0000) begin
      miscompares++;
      $display("FAIL basic_done got v=%b tout=%b gnt=%b want 0/0/0000", gnt_v, tout, gnt);
    end
  endtask

  task automatic test_hold_limit();
    req = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      step();
      vectors++;
      if (gnt !== 4'b1000 || gnt_id !== 2'd3 || gnt_v !== 1'b1 || tout !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_cyc%0d got gnt=%b id=%0d v=%b tout=%b want 1000/3/1/0", i, gnt, gnt_id, gnt_v, tout);
      end
    end
    step();
    vectors++;
    if (gnt_v !== 1'b0 || tout !== 1'b1 || gnt !== 4'b0000) begin
      miscompares++;
      $display("FAIL hold_release got v=%b tout=%b gnt=%b want 0/1/0000", gnt_v, tout, gnt);
    end
    step();
    vectors++;
    if (gnt !== 4'b1000 || gnt_v !== 1'b1 || tout !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_regrant got gnt=%b v=%b tout=%b want 1000/1/0", gnt, gnt_v, tout);
    end
    req = 4'b0000;
    step();
    vectors++;
    if (gnt_v !== 1'b0 || tout !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_drop got v=%b tout=%b want 0/0", gnt_v, tout);
    end
  endtask

  task automatic test_no_preempt();
    req = 4'b0010;
    step();
    vectors++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      miscompares++;
      $display("FAIL np_grant got gnt=%b id=%0d want 0010/1", gnt, gnt_id);
    end
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (gnt !== 4'b0010 || gnt_v !== 1'b1) begin
        miscompares++;
        $display("FAIL np_keep cyc %0d got gnt=%b v=%b want 0010/1", i, gnt, gnt_v);
      end
    end
    req = 4'b1000;
    step();
    vectors++;
    if (gnt_v !== 1'b0 || tout !== 1'b0) begin
      miscompares++;
      $display("FAIL np_release got v=%b tout=%b want 0/0", gnt_v, tout);
    end
    step();
    vectors++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      miscompares++;
      $display("FAIL np_next got gnt=%b id=%0d want 1000/3", gnt, gnt_id);
    end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_coincide();
    req = 4'b1111;
    step();
    for (int i = 1; i < 16; i++) step();
    vectors++;
    if (gnt !== 4'b1000 || gnt_v !== 1'b1) begin
      miscompares++;
      $display("FAIL coin_last got gnt=%b v=%b want 1000/1", gnt, gnt_v);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b0000;
    vectors++;
    if (gnt_v !== 1'b0 || tout !== 1'b0) begin
      miscompares++;
      $display("FAIL coin_release got v=%b tout=%b want 0/0", gnt_v, tout);
    end
    step();
  endtask

  task automatic test_async_reset();
    req = 4'b0010;
    step();
    vectors++;
    if (gnt !== 4'b0010) begin
      miscompares++;
      $display("FAIL ar_grant got gnt=%b want 0010", gnt);
    end
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (gnt !== 4'b0000 || gnt_v !== 1'b0) begin
      miscompares++;
      $display("FAIL ar_drop got gnt=%b v=%b want 0000/0", gnt, gnt_v);
    end
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0001;
    step();
    vectors++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_v !== 1'b1) begin
      miscompares++;
      $display("FAIL ar_regrant got gnt=%b id=%0d v=%b want 0001/0/1", gnt, gnt_id, gnt_v);
    end
    req = 4'b0000;
    step();
  endtask

`ifdef ARB_RR_EN
  task automatic test_round_robin();
    logic [1:0] exp_id [5];
    exp_id = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
    rst = 1'b1;
    #2;
    @(negedge clk);
    rst  = 1'b0;
    req  = 4'b1111;
    done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (gnt_v !== 1'b1 || gnt_id !== exp_id[i]) begin
        miscompares++;
        $display("FAIL rr_grant%0d got id=%0d v=%b want %0d/1", i, gnt_id, gnt_v, exp_id[i]);
      end
      step();
      vectors++;
      if (gnt_v !== 1'b0) begin
        miscompares++;
        $display("FAIL rr_dead%0d got v=%b want 0", i, gnt_v);
      end
    end
    req  = 4'b0000;
    done = 1'b0;
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_idle();
    test_basic();
    test_hold_limit();
    test_no_preempt();
    test_coincide();
    test_async_reset();
`ifdef ARB_RR_EN
    test_round_robin();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prio_arb_4ch.md
PRIO_ARB_4CH -- requirements
Module: prio_arb_4ch

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum number of consecutive cycles one owner SHALL hold the grant (legal range 2..256).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  request per requester; bit 3 is highest fixed priority.
REQ-005 done  input  1  owner finished; SHALL be ignored while gnt_v is 0.
REQ-006 gnt  output  4  registered one-hot grant; all zero when no owner.
REQ-007 gnt_id  output  2  encoded index of current owner; 0 when gnt_v is 0.
REQ-008 gnt_v  output  1  high when exactly one gnt bit is set.
REQ-009 tout  output  1  one-cycle pulse on the cycle after a hold-limit forced release.

Function
REQ-010 The FSM SHALL have two states: IDLE (no owner) and BUSY (owner held).
REQ-011 IDLE: if req != 0 at a rising edge, the next state SHALL be BUSY with gnt set to the winner's one-hot bit, gnt_id to its index and gnt_v to 1; grant latency is exactly 1 cycle from sampled req.
REQ-012 IDLE with req == 0 SHALL remain IDLE with gnt, gnt_id and gnt_v all 0.
REQ-013 Fixed winner (macro absent): highest set index of req (3 > 2 > 1 > 0).
REQ-014 BUSY SHALL release to IDLE on the next edge when done == 1, or req[gnt_id] == 0, or hold_cnt == MAX_HOLD-1.
REQ-015 hold_cnt SHALL be 0 in the first BUSY cycle and increment by 1 each further BUSY cycle; an owner SHALL never hold more than MAX_HOLD cycles.
REQ-016 Requests from non-owners SHALL NOT preempt a BUSY owner.
REQ-017 After any release, gnt_v SHALL be 0 for exactly one cycle (IDLE) before the next grant; back-to-back grants without a dead cycle are forbidden.
REQ-018 tout SHALL pulse high for one cycle (coincident with the IDLE cycle) only when release is caused solely by the hold limit.
REQ-019 Simultaneous done (or owner req drop) with hold_cnt == MAX_HOLD-1 SHALL be a normal release with tout = 0.
REQ-020 hold_cnt width SHALL be clog2(MAX_HOLD); counter SHALL reset to 0 on every transition into BUSY.
REQ-021 gnt, gnt_id, gnt_v and tout SHALL be driven directly from registers (no combinational path from req or done).

Reset
REQ-022 On rst high, state SHALL immediately become IDLE; gnt = 4'b0000, gnt_id = 0, gnt_v = 0, tout = 0, hold_cnt = 0, last owner pointer = 0.
REQ-023 rst asserted mid-grant SHALL drop the grant asynchronously; first grant after rst deassertion follows REQ-011.

Configuration
REQ-024 Macro ARB_RR_EN: when defined, the winner SHALL be chosen round-robin; when undefined, fixed priority per REQ-013 and no pointer register exists.
REQ-025 With ARB_RR_EN, a pointer last SHALL store gnt_id on each grant; search order SHALL be last-1, last-2, last-3, last (mod 4, descending with wrap), first set req bit wins.
REQ-026 With ARB_RR_EN and reset pointer 0, the first search order SHALL be 3,2,1,0 (identical to fixed priority).

Verification
REQ-027 rst, then req=4'b0101 -> next cycle gnt=4'b0100, gnt_id=2, gnt_v=1; done pulse -> following cycle gnt_v=0, tout=0.
REQ-028 req=4'b1111 held continuously, MAX_HOLD=16, fixed priority -> gnt=4'b1000 for 16 cycles, 1 IDLE cycle with tout=1, then gnt=4'b1000 again.
REQ-029 ARB_RR_EN, req=4'b1111 held, done every grant cycle -> gnt_id sequence 3,2,1,0,3 with one dead cycle between each.
REQ-030 Owner 1 granted, then req=4'b1010 -> owner stays 1 until req[1] drops; next grant goes to 3.
REQ-031 rst asserted while gnt=4'b0010 -> gnt=0, gnt_v=0 without waiting for clk; after release with req=4'b0001 -> gnt=4'b0001 one cycle later.
REQ-032 done and hold limit coincide (hold_cnt=15) -> release, tout stays 0.
